// File: rtl/sos_seq_ctrl.sv
// sos_seq_ctrl: shares one SOS engine across a NUM_SEC-section IIR cascade with one sample in flight.
// Build option SOS_TIMEOUT_EN adds an engine-ack watchdog that sets sticky err and ends the run.
module sos_seq_ctrl #(
   parameter int DW          = 24,
   parameter int NUM_SEC     = 4,
   parameter int SEC_W       = 2,
   parameter int NUM_SAMPLES = 2048,
   parameter int ADDR_W      = 11,
   parameter int TIMEOUT     = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic signed [DW-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 eng_clr,
   output logic                 eng_req,
   output logic [SEC_W-1:0]     eng_sec,
   output logic signed [DW-1:0] eng_din,
   input  logic                 eng_ack,
   input  logic signed [DW-1:0] eng_dout,
   output logic signed [DW-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ADDR_W-1:0]    out_addr,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_EMIT, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [SEC_W-1:0]      sec_q, sec_d;
   logic [ADDR_W-1:0]     count_q, count_d;
   logic signed [DW-1:0]  work_q, work_d;
   logic                  in_ready_q, in_ready_d;
   logic                  eng_clr_q, eng_clr_d;
   logic                  eng_req_q, eng_req_d;
   logic                  out_valid_q, out_valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
`ifdef SOS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]         wait_cnt_q, wait_cnt_d;
   logic                  err_q, err_d;
`endif

   always_comb begin
      state_d   = state_q;
      sec_d     = sec_q;
      count_d   = count_q;
      work_d    = work_q;
      eng_clr_d = 1'b0;
`ifdef SOS_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_LOAD;
               count_d   = '0;
               eng_clr_d = 1'b1;
`ifdef SOS_TIMEOUT_EN
               err_d     = 1'b0;
`endif
            end
         end
         S_LOAD: begin
            if (in_valid && in_ready_q) begin
               work_d  = in_data;
               sec_d   = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef SOS_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end
         S_WAIT: begin
            // an ack always wins over a watchdog expiry in the same cycle
            if (eng_ack) begin
               work_d = eng_dout;
               if (sec_q == SEC_W'(NUM_SEC - 1)) begin
                  state_d = S_EMIT;
               end else begin
                  sec_d   = sec_q + 1'b1;
                  state_d = S_ISSUE;
               end
            end
`ifdef SOS_TIMEOUT_EN
            else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
`endif
         end
         S_EMIT: begin
            if (out_ready) begin
               if (count_q == ADDR_W'(NUM_SAMPLES - 1)) begin
                  state_d = S_DONE;
               end else begin
                  count_d = count_q + 1'b1;
                  state_d = S_LOAD;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // strobes are registered from the next state so they line up with state_q
      in_ready_d  = (state_d == S_LOAD);
      eng_req_d   = (state_d == S_ISSUE);
      out_valid_d = (state_d == S_EMIT);
      done_d      = (state_d == S_DONE);
      busy_d      = (state_d == S_LOAD) || (state_d == S_ISSUE) ||
                    (state_d == S_WAIT) || (state_d == S_EMIT);
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q     <= S_IDLE;
         sec_q       <= '0;
         count_q     <= '0;
         work_q      <= '0;
         in_ready_q  <= 1'b0;
         eng_clr_q   <= 1'b0;
         eng_req_q   <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef SOS_TIMEOUT_EN
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sec_q       <= sec_d;
         count_q     <= count_d;
         work_q      <= work_d;
         in_ready_q  <= in_ready_d;
         eng_clr_q   <= eng_clr_d;
         eng_req_q   <= eng_req_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef SOS_TIMEOUT_EN
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign eng_clr   = eng_clr_q;
   assign eng_req   = eng_req_q;
   assign eng_sec   = sec_q;
   assign eng_din   = work_q;
   assign out_data  = work_q;
   assign out_valid = out_valid_q;
   assign out_addr  = count_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef SOS_TIMEOUT_EN
   assign err = err_q;
`else
   // no watchdog: WAIT blocks until the engine answers
   assign err = 1'b0 && (TIMEOUT != 0);
`endif
endmodule

// File: tb/tb_sos_seq_ctrl.sv
// Bench for sos_seq_ctrl: randomized samples and engine latency against a queue-based reference.
// Engine model returns din+1 after L cycles, so a sample leaves the cascade as in+NUM_SEC.
module tb_sos_seq_ctrl;
   localparam int DW = 24;
   localparam int NS = 2048;
   localparam int NSEC = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          eng_clr, eng_req;
   logic [1:0]    eng_sec;
   logic [DW-1:0] eng_din;
   logic          eng_ack = 1'b0;
   logic [DW-1:0] eng_dout = '0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [10:0]   out_addr;
   logic          busy, done, err;

   int checks = 0;
   int failures = 0;

   // engine model state
   int            eng_pend = 0;
   int            eng_l = 2;
   bit            eng_rand = 1'b0;
   bit            eng_en = 1'b1;
   logic [DW-1:0] eng_hold = '0;
   int            clr_cnt = 0;
   logic [1:0]    req_sec[$];
   logic [DW-1:0] req_din[$];
   logic [DW-1:0] ins[NS];

   sos_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .eng_clr(eng_clr), .eng_req(eng_req), .eng_sec(eng_sec), .eng_din(eng_din),
      .eng_ack(eng_ack), .eng_dout(eng_dout),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      eng_ack = 1'b0;
      if (rst_n) begin
         eng_pend = 0;
      end else begin
         if (eng_pend > 0) begin
            eng_pend--;
            if (eng_pend == 0) begin
               eng_ack  = 1'b1;
               eng_dout = eng_hold + 1'b1;
            end
         end
         if (eng_req) begin
            req_sec.push_back(eng_sec);
            req_din.push_back(eng_din);
            eng_hold = eng_din;
            if (eng_en) eng_pend = eng_rand ? int'($urandom_range(1, 4)) : eng_l;
         end
         if (eng_clr) clr_cnt++;
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
   endtask

   task automatic wait_for(input int sel, input int limit, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < limit; n++) begin
         @(negedge clk);
         if ((sel == 0 && in_ready) || (sel == 1 && out_valid) || (sel == 2 && eng_req)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({in_ready, eng_clr, eng_req, out_valid, busy, done, err} !== 7'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=0000000", {in_ready, eng_clr, eng_req, out_valid, busy, done, err});
      end
      checks++;
      if (eng_sec !== 0 || eng_din !== 0 || out_data !== 0 || out_addr !== 0) begin
         failures++;
         $display("FAIL reset_data sec=%0d din=%0d out=%0d addr=%0d exp all 0", eng_sec, eng_din, out_data, out_addr);
      end
   endtask

   task automatic test_single();
      int lat;
      eng_rand = 1'b0; eng_l = 2; eng_en = 1'b1; out_ready = 1'b1;
      req_sec.delete(); req_din.delete(); clr_cnt = 0;
      pulse_start();
      checks++;
      if (eng_clr !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL single_start clr=%b in_ready=%b busy=%b exp 1 1 1", eng_clr, in_ready, busy);
      end
      in_data = 24'd100; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== 12) begin failures++; $display("FAIL single_latency got=%0d exp=12", lat); end
      checks++;
      if (out_data !== 24'd104) begin failures++; $display("FAIL single_data got=%0d exp=104", out_data); end
      checks++;
      if (out_addr !== 0) begin failures++; $display("FAIL single_addr got=%0d exp=0", out_addr); end
      checks++;
      if (req_sec.size() !== NSEC) begin failures++; $display("FAIL single_reqs got=%0d exp=%0d", req_sec.size(), NSEC); end
      for (int k = 0; k < NSEC && k < req_sec.size(); k++) begin
         checks++;
         if (req_sec[k] !== 2'(k) || req_din[k] !== DW'(100 + k)) begin
            failures++;
            $display("FAIL single_req%0d sec=%0d din=%0d exp sec=%0d din=%0d", k, req_sec[k], req_din[k], k, 100 + k);
         end
      end
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL single_after in_ready=%b out_valid=%b done=%b exp 1 0 0", in_ready, out_valid, done);
      end
      checks++;
      if (clr_cnt !== 1) begin failures++; $display("FAIL single_clr_count got=%0d exp=1", clr_cnt); end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] d, exp;
      bit ok;
      out_ready = 1'b0;
      d = DW'($urandom);
      exp = d + DW'(NSEC);
      in_data = d; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_for(1, 100, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bp_wait out_valid=0 exp=1"); return; end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp || out_addr !== 11'd1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold%0d v=%b data=%h addr=%0d in_ready=%b exp 1 %h 1 0", k, out_valid, out_data, out_addr, in_ready, exp);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_full_run();
      bit ok;
      int bad;
      logic [DW-1:0] exp;
      do_reset();
      req_sec.delete(); req_din.delete(); clr_cnt = 0;
      eng_rand = 1'b1; eng_en = 1'b1; out_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < NS; i++) begin
         if (!in_ready) begin
            wait_for(0, 100, ok);
            if (!ok) begin checks++; failures++; $display("FAIL full_in_ready sample=%0d got=0 exp=1", i); return; end
         end
         repeat ($urandom_range(0, 1)) @(negedge clk);
         ins[i] = DW'($urandom);
         in_data = ins[i]; in_valid = 1'b1;
         if (i == 100 || i == 1500) start = 1'b1;
         @(negedge clk);
         in_valid = 1'b0; start = 1'b0;
         if (i == 700) begin
            @(negedge clk);
            pulse_start();
         end
         wait_for(1, 100, ok);
         if (!ok) begin checks++; failures++; $display("FAIL full_out_valid sample=%0d got=0 exp=1", i); return; end
         if (i == 300) start = 1'b1;
         exp = ins[i] + DW'(NSEC);
         checks++;
         if (out_data !== exp) begin failures++; $display("FAIL full_data sample=%0d got=%h exp=%h", i, out_data, exp); end
         checks++;
         if (out_addr !== 11'(i)) begin failures++; $display("FAIL full_addr got=%0d exp=%0d", out_addr, i); end
         repeat ($urandom_range(0, 1)) @(negedge clk);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0; start = 1'b0;
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL full_done done=%b busy=%b in_ready=%b out_valid=%b exp 1 0 0 0", done, busy, in_ready, out_valid);
      end
      checks++;
      if (clr_cnt !== 1) begin failures++; $display("FAIL full_clr_count got=%0d exp=1", clr_cnt); end
      bad = 0;
      for (int k = 0; k < req_sec.size() && k < NS * NSEC; k++) begin
         if (req_sec[k] !== 2'(k % NSEC) || req_din[k] !== ins[k / NSEC] + DW'(k % NSEC)) bad++;
      end
      checks++;
      if (req_sec.size() !== NS * NSEC || bad != 0) begin
         failures++;
         $display("FAIL full_engine_seq reqs=%0d bad=%0d exp reqs=%0d bad=0", req_sec.size(), bad, NS * NSEC);
      end
   endtask

   task automatic test_mid_reset();
      bit ok;
      int n;
      logic [DW-1:0] d;
      clr_cnt = 0;
      pulse_start();
      checks++;
      if (eng_clr !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL restart_from_done clr=%b done=%b in_ready=%b exp 1 0 1", eng_clr, done, in_ready);
      end
      eng_rand = 1'b0; eng_l = 4;
      in_data = DW'($urandom); in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!(eng_req && eng_sec == 2'd2) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin failures++; $display("FAIL midrst_sec2 got no req for sec 2 exp req"); return; end
      @(negedge clk);
      clr_cnt = 0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (eng_req !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || eng_clr !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midrst_idle req=%b busy=%b in_ready=%b clr=%b ov=%b exp all 0", eng_req, busy, in_ready, eng_clr, out_valid);
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (clr_cnt !== 0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_no_clr clr_cnt=%0d busy=%b exp 0 0", clr_cnt, busy); end
      pulse_start();
      checks++;
      if (eng_clr !== 1'b1) begin failures++; $display("FAIL midrst_fresh_clr got=%b exp=1", eng_clr); end
      d = DW'($urandom);
      in_data = d; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_for(1, 100, ok);
      checks++;
      if (!ok || out_addr !== 0 || out_data !== d + DW'(NSEC)) begin
         failures++;
         $display("FAIL midrst_first ok=%b addr=%0d data=%h exp 1 0 %h", ok, out_addr, out_data, d + DW'(NSEC));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

`ifdef SOS_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      do_reset();
      pulse_start();
      eng_en = 1'b0;
      in_data = DW'($urandom); in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_for(2, 20, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL to_req got no eng_req exp 1"); return; end
      repeat (64) @(negedge clk);
      checks++;
      if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL to_early done=%b err=%b exp 0 0", done, err); end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL to_fire done=%b err=%b busy=%b exp 1 1 0", done, err, busy);
      end
      pulse_start();
      checks++;
      if (err !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL to_clear err=%b done=%b exp 0 0", err, done); end
      eng_en = 1'b1; eng_rand = 1'b0; eng_l = 64;
      in_data = DW'($urandom); in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_for(2, 20, ok);
      repeat (65) @(negedge clk);
      checks++;
      if (!ok || err !== 1'b0 || eng_req !== 1'b1 || eng_sec !== 2'd1) begin
         failures++;
         $display("FAIL to_ack_wins err=%b req=%b sec=%0d exp 0 1 1", err, eng_req, eng_sec);
      end
      do_reset();
   endtask
`endif

   initial begin
      #5ms;
      $display("FAIL watchdog sim time expired");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_full_run();
      test_mid_reset();
`ifdef SOS_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
